// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between two requesting masters, the arbiter and the SRAM strobe port.
// slave = arbiter side, master = environment (masters plus SRAM) side.
interface sram_port_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic          sram_cs;
  logic          sram_re;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data_in;
  logic [DW-1:0] sram_data_out;
  logic          busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output sram_cs, sram_re, sram_we, sram_addr, sram_data_in,
    input  sram_data_out,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  sram_cs, sram_re, sram_we, sram_addr, sram_data_in,
    output sram_data_out,
    input  busy
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-master round-robin arbiter that serialises complete read/write requests onto a
// single-port SRAM, waits out its read latency and returns data with a one-cycle ack.
module sram_port_arbiter #(
  parameter int DW     = 8,
  parameter int AW     = 3,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t        state, state_nx;
  logic          last_grant;
  logic          grant;
  logic          win;
  logic          take;
  logic          lat_we;
  logic [1:0]    cnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    state_nx = state;
    win      = grant;
    take     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          take     = 1'b1;
          state_nx = ISSUE;
          // On a tie the master that did not win last time goes next.
          win      = (bus.m0_req && bus.m1_req) ? ~last_grant : bus.m1_req;
        end
      end
      ISSUE:   state_nx = lat_we ? ACK : WAIT;
      WAIT:    if (cnt == 2'd0) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sel_we    = win ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      grant            <= 1'b0;
      lat_we           <= 1'b0;
      cnt              <= 2'd0;
      bus.sram_cs      <= 1'b0;
      bus.sram_re      <= 1'b0;
      bus.sram_we      <= 1'b0;
      bus.sram_addr    <= '0;
      bus.sram_data_in <= '0;
      bus.m0_ack       <= 1'b0;
      bus.m1_ack       <= 1'b0;
      bus.m0_rdata     <= '0;
      bus.m1_rdata     <= '0;
      bus.busy         <= 1'b0;
    end else begin
      state <= state_nx;

      // The strobe-bus address/data registers double as the request latch.
      if (take) begin
        grant         <= win;
        last_grant    <= win;
        lat_we        <= sel_we;
        bus.sram_addr <= sel_addr;
        if (sel_we) bus.sram_data_in <= sel_wdata;
      end

      if (state == ISSUE)                    cnt <= 2'(RD_LAT - 1);
      else if (state == WAIT && cnt != 2'd0) cnt <= cnt - 2'd1;

      // Outputs are registered from the next state so they line up with it.
      bus.sram_cs <= (state_nx == ISSUE) || (state_nx == WAIT);
      bus.sram_re <= take && !sel_we;
      bus.sram_we <= take && sel_we;
      bus.m0_ack  <= (state_nx == ACK) && !grant;
      bus.m1_ack  <= (state_nx == ACK) && grant;
      bus.busy    <= (state_nx != IDLE);

      if (state == WAIT && cnt == 2'd0) begin
        if (grant) bus.m1_rdata <= bus.sram_data_out;
        else       bus.m0_rdata <= bus.sram_data_out;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: per-cycle vector table, a timeline reference model
// under random and directed traffic, and a directed RD_LAT=3 read sequence.
module tb_sram_port_arbiter;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.DW(DW), .AW(AW)) bus_a ();
  sram_port_arbiter_if #(.DW(DW), .AW(AW)) bus_b ();

  sram_port_arbiter #(.DW(DW), .AW(AW), .RD_LAT(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  sram_port_arbiter #(.DW(DW), .AW(AW), .RD_LAT(LAT_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // SRAM models: read data shows up RD_LAT edges after re is sampled, zero otherwise.
  logic [7:0] mem_a [8];
  logic [7:0] mem_b [8];
  logic [7:0] da;
  logic [7:0] db [3];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem_a[i] <= 8'h00;
      da <= 8'h00;
    end else begin
      if (bus_a.sram_cs && bus_a.sram_we) mem_a[bus_a.sram_addr] <= bus_a.sram_data_in;
      da <= (bus_a.sram_cs && bus_a.sram_re) ? mem_a[bus_a.sram_addr] : 8'h00;
    end
  end
  assign bus_a.sram_data_out = da;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem_b[i] <= 8'h00;
      for (int i = 0; i < 3; i++) db[i] <= 8'h00;
    end else begin
      if (bus_b.sram_cs && bus_b.sram_we) mem_b[bus_b.sram_addr] <= bus_b.sram_data_in;
      db[0] <= (bus_b.sram_cs && bus_b.sram_re) ? mem_b[bus_b.sram_addr] : 8'h00;
      db[1] <= db[0];
      db[2] <= db[1];
    end
  end
  assign bus_b.sram_data_out = db[2];

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_a(input logic r0, input logic w0, input logic [2:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [2:0] a1, input logic [7:0] d1);
    bus_a.m0_req = r0; bus_a.m0_we = w0; bus_a.m0_addr = a0; bus_a.m0_wdata = d0;
    bus_a.m1_req = r1; bus_a.m1_we = w1; bus_a.m1_addr = a1; bus_a.m1_wdata = d1;
  endtask

  typedef struct {
    logic       rst;
    logic       r0, w0;
    logic [2:0] a0;
    logic [7:0] d0;
    logic       r1, w1;
    logic [2:0] a1;
    logic [7:0] d1;
    logic       ack0, ack1, cs, re, we, busy;
    logic [2:0] addr;
    logic [7:0] din, rd0, rd1;
  } vec_t;

  function automatic vec_t v(input int rst_i, input int r0, input int w0, input int a0, input int d0,
                             input int r1, input int w1, input int a1, input int d1,
                             input int ack0, input int ack1, input int cs, input int re, input int we,
                             input int busy, input int addr, input int din, input int rd0, input int rd1);
    vec_t t;
    t.rst  = (rst_i != 0);
    t.r0   = (r0 != 0);  t.w0 = (w0 != 0);  t.a0 = 3'(a0);  t.d0 = 8'(d0);
    t.r1   = (r1 != 0);  t.w1 = (w1 != 0);  t.a1 = 3'(a1);  t.d1 = 8'(d1);
    t.ack0 = (ack0 != 0); t.ack1 = (ack1 != 0); t.cs = (cs != 0);
    t.re   = (re != 0);   t.we = (we != 0);     t.busy = (busy != 0);
    t.addr = 3'(addr); t.din = 8'(din); t.rd0 = 8'(rd0); t.rd1 = 8'(rd1);
    return t;
  endfunction

  // Timeline model: grant at the sampling edge, strobes on that edge, ack RD_LAT
  // edges later for reads, next sample two edges after the ack.
  task automatic run_model(input int ncyc, input int mode);
    logic [7:0] ref_mem [8];
    logic       r [2];
    logic       mwe [2];
    logic [2:0] ma [2];
    logic [7:0] md [2];
    logic [7:0] erd [2];
    int         lg, w, s_edge, a_edge, nxt;
    logic       t_we, newp;
    logic [2:0] t_a, seq;
    logic [7:0] t_d, t_rd;

    rst = 1'b1;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    lg = 1; w = 0; s_edge = -10; a_edge = -10; nxt = 0;
    t_we = 1'b0; t_a = 3'd0; t_d = 8'h00; t_rd = 8'h00; seq = 3'd0;
    for (int m = 0; m < 2; m++) begin
      erd[m] = 8'h00;
      r[m]   = (mode == 1) || (mode == 2 && m == 0);
      mwe[m] = (mode == 2) || ($urandom_range(1) == 1);
      ma[m]  = (mode == 2) ? seq : 3'($urandom_range(7));
      md[m]  = 8'($urandom_range(255));
    end
    if (mode == 2) seq = seq + 3'd1;

    for (int e = 0; e < ncyc; e++) begin
      drive_a(r[0], mwe[0], ma[0], md[0], r[1], mwe[1], ma[1], md[1]);
      if (e >= nxt && (r[0] || r[1])) begin
        w      = (r[0] && r[1]) ? 1 - lg : (r[1] ? 1 : 0);
        lg     = w;
        s_edge = e;
        t_we   = mwe[w]; t_a = ma[w]; t_d = md[w];
        a_edge = e + 1 + (t_we ? 0 : LAT_A);
        nxt    = a_edge + 2;
        if (t_we) ref_mem[t_a] = t_d;
        else      t_rd = ref_mem[t_a];
      end
      @(negedge clk);
      if (e == a_edge && !t_we) erd[w] = t_rd;

      chk1($sformatf("m%0d e%0d busy", mode, e), bus_a.busy,    (e >= s_edge && e <= a_edge));
      chk1($sformatf("m%0d e%0d cs", mode, e),   bus_a.sram_cs, (e >= s_edge && e < a_edge));
      chk1($sformatf("m%0d e%0d re", mode, e),   bus_a.sram_re, (e == s_edge && !t_we));
      chk1($sformatf("m%0d e%0d we", mode, e),   bus_a.sram_we, (e == s_edge && t_we));
      chk1($sformatf("m%0d e%0d ack0", mode, e), bus_a.m0_ack,  (e == a_edge && w == 0));
      chk1($sformatf("m%0d e%0d ack1", mode, e), bus_a.m1_ack,  (e == a_edge && w == 1));
      chk8($sformatf("m%0d e%0d rd0", mode, e),  bus_a.m0_rdata, erd[0]);
      chk8($sformatf("m%0d e%0d rd1", mode, e),  bus_a.m1_rdata, erd[1]);
      if (e == s_edge) chk8($sformatf("m%0d e%0d addr", mode, e), 8'(bus_a.sram_addr), 8'(t_a));
      if (e == s_edge && t_we) chk8($sformatf("m%0d e%0d din", mode, e), bus_a.sram_data_in, t_d);

      for (int m = 0; m < 2; m++) begin
        newp = 1'b0;
        if (r[m] && e == a_edge && w == m) begin
          r[m] = (mode != 0) || ($urandom_range(1) == 1);
          newp = r[m];
        end else if (!r[m] && mode == 0) begin
          r[m] = ($urandom_range(2) == 0);
          newp = r[m];
        end else if (r[m] && mode == 0 && w == m && e >= s_edge && e < a_edge) begin
          mwe[m] = ~mwe[m]; ma[m] = ~ma[m]; md[m] = ~md[m];
        end
        if (newp) begin
          mwe[m] = (mode == 2) || ($urandom_range(1) == 1);
          ma[m]  = (mode == 2) ? seq : 3'($urandom_range(7));
          md[m]  = 8'($urandom_range(255));
          if (mode == 2) seq = seq + 3'd1;
        end
      end
    end
  endtask

  vec_t tbl [$];
  int   re_n, ack_n, ack_k;

  initial begin
    bus_b.m0_req = 1'b0; bus_b.m0_we = 1'b0; bus_b.m0_addr = 3'd0; bus_b.m0_wdata = 8'h00;
    bus_b.m1_req = 1'b0; bus_b.m1_we = 1'b0; bus_b.m1_addr = 3'd0; bus_b.m1_wdata = 8'h00;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);

    //             rst r0 w0 a0 d0     r1 w1 a1 d1     ak0 ak1 cs re we by addr din   rd0   rd1
    tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(0, 1, 1, 3, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 3, 8'hA5, 8'h00, 8'h00));
    tbl.push_back(v(0, 1, 1, 3, 8'hA5, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 0, 3, 8'h00, 0, 0, 1, 1, 0, 1, 3, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 0, 3, 8'h00, 0, 0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 0, 3, 8'h00, 0, 1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'hA5));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hA5));
    tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(0, 1, 1, 7, 8'h11, 1, 0, 7, 8'h00, 0, 0, 1, 0, 1, 1, 7, 8'h11, 8'h00, 8'h00));
    tbl.push_back(v(0, 1, 1, 7, 8'h11, 1, 0, 7, 8'h00, 1, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 0, 7, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 0, 7, 8'h00, 0, 0, 1, 1, 0, 1, 7, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 0, 7, 8'h00, 0, 0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 0, 7, 8'h00, 0, 1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h11));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11));
    tbl.push_back(v(0, 1, 0, 7, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 7, 8'h00, 8'h00, 8'h11));
    tbl.push_back(v(0, 1, 0, 7, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h11));
    tbl.push_back(v(1, 1, 0, 7, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h3C, 0, 0, 1, 0, 1, 1, 0, 8'h3C, 8'h00, 8'h00));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h3C, 0, 1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      drive_a(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      @(negedge clk);
      chk1($sformatf("v%0d ack0", i), bus_a.m0_ack,   tbl[i].ack0);
      chk1($sformatf("v%0d ack1", i), bus_a.m1_ack,   tbl[i].ack1);
      chk1($sformatf("v%0d cs", i),   bus_a.sram_cs,  tbl[i].cs);
      chk1($sformatf("v%0d re", i),   bus_a.sram_re,  tbl[i].re);
      chk1($sformatf("v%0d we", i),   bus_a.sram_we,  tbl[i].we);
      chk1($sformatf("v%0d busy", i), bus_a.busy,     tbl[i].busy);
      chk8($sformatf("v%0d rd0", i),  bus_a.m0_rdata, tbl[i].rd0);
      chk8($sformatf("v%0d rd1", i),  bus_a.m1_rdata, tbl[i].rd1);
      if (tbl[i].re || tbl[i].we || tbl[i].rst)
        chk8($sformatf("v%0d addr", i), 8'(bus_a.sram_addr), 8'(tbl[i].addr));
      if (tbl[i].we || tbl[i].rst)
        chk8($sformatf("v%0d din", i), bus_a.sram_data_in, tbl[i].din);
    end

    run_model(400, 0);
    run_model(40, 1);
    run_model(14, 2);

    // RD_LAT=3 instance: write 0x5C to addr 2, then read it back.
    rst = 1'b1;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    bus_b.m0_req = 1'b1; bus_b.m0_we = 1'b1; bus_b.m0_addr = 3'd2; bus_b.m0_wdata = 8'h5C;
    @(negedge clk);
    chk1("b wr we", bus_b.sram_we, 1'b1);
    chk8("b wr addr", 8'(bus_b.sram_addr), 8'h02);
    chk8("b wr din", bus_b.sram_data_in, 8'h5C);
    @(negedge clk);
    chk1("b wr ack", bus_b.m0_ack, 1'b1);
    bus_b.m0_we = 1'b0; bus_b.m0_wdata = 8'hFF;
    @(negedge clk);
    chk1("b gap busy", bus_b.busy, 1'b0);
    re_n = 0; ack_n = 0; ack_k = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus_b.sram_re) re_n++;
      if (bus_b.m0_ack) begin
        ack_n++;
        ack_k = k;
        bus_b.m0_req = 1'b0;
      end
    end
    chkn("b rd re cycles", re_n, 1);
    chkn("b rd ack count", ack_n, 1);
    chkn("b rd ack edge", ack_k, 1 + LAT_B);
    chk8("b rd data", bus_b.m0_rdata, 8'h5C);
    chk1("b rd busy", bus_b.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
